mips_div_unit: RTL and testbench
================================

Name: mips_div_unit

Overview:
Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the E stage. Produces the 64-bit {HI=remainder, LO=quotient} value that travels down the pipeline to the HI/LO register file. It stalls the pipeline while iterating, and can be annulled by an exception or branch flush.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH bits.
CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  E-stage instruction is DIV/DIVU (level, held while stalled)
is_signed  input  1  1 = DIV, 0 = DIVU; sampled with start in IDLE
annul  input  1  flush; abort any operation in progress
opdata1  input  WIDTH  dividend (rs); sampled in IDLE when start=1
opdata2  input  WIDTH  divisor (rt); sampled in IDLE when start=1
result  output  2*WIDTH  {remainder, quotient}
result_valid  output  1  result holds the answer for the current start
stall_req  output  1  request pipeline stall of E and earlier stages

Behaviour:
- Reset: state=IDLE, result=0, result_valid=0, counter=0. Reset in any state, mid-iteration included, discards the operation.
- States: IDLE, ZERO, CALC, DONE.
- IDLE: if start & ~annul, latch |opdata1|, |opdata2| (two's-complement magnitude when is_signed; raw otherwise), both sign bits and is_signed. Go to ZERO if opdata2==0, else to CALC with counter=0 and partial remainder=0.
- ZERO: one cycle. Load result={opdata1 as latched unsigned/raw, all-ones}, i.e. HI=original dividend, LO=32'hFFFF_FFFF. No sign correction. Go to DONE.
- CALC: one quotient bit per cycle, MSB first. Shift {rem,dvd} left 1. If rem >= divisor, rem -= divisor and quotient bit=1. Counter increments; after the WIDTH-th iteration (counter==WIDTH-1) go to DONE.
- DONE entry: if signed and sign1^sign2, negate the quotient. If signed and sign1, negate the remainder. Write result; result_valid=1.
- DONE: hold result and result_valid while start=1 & annul=0. When start=0, go to IDLE and clear result_valid. result keeps its last value.
- Latency: start sampled in IDLE at cycle 0. For a nonzero divisor, result_valid=1 at cycle WIDTH+1 (33). For a zero divisor, result_valid=1 at cycle 2.
- stall_req = (state==IDLE & start & ~annul) | state==ZERO | state==CALC. It is combinational and deasserts in the first DONE cycle.
- annul=1 in any state: next state IDLE, result_valid=0, no result update. annul has priority over start and completion.
- Overflow: signed 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000 and HI=0 (natural wrap). No exception is raised.
- Operands are ignored outside IDLE. Changes to opdata1/opdata2 during CALC have no effect.
- Back-to-back divides: the next start is accepted only from IDLE. At least one cycle with start=0 (the pipeline advance) separates two operations.

Test Plan:
- DIVU 7/2: start=1, op1=7, op2=2 → stall_req=1 for cycles 0–32, result_valid=1 at cycle 33, result=64'h0000_0001_0000_0003, stall_req=0 that cycle.
- DIV -7/2: op1=32'hFFFF_FFF9, op2=2, is_signed=1 → LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. Also 7/-2 → LO=FFFF_FFFD, HI=1.
- Divide by zero: op1=32'h1234_5678, op2=0, either signedness → valid at cycle 2, HI=32'h1234_5678, LO=32'hFFFF_FFFF.
- Overflow: DIV 0x8000_0000 / 0xFFFF_FFFF → LO=0x8000_0000, HI=0, no hang. DIVU 0xFFFF_FFFF/1 → LO=FFFF_FFFF, HI=0.
- annul at cycle 10 of CALC → IDLE next cycle, result_valid never rises, stall_req drops. A new DIVU 100/7 then completes with LO=14, HI=2 after 33 cycles.
- rst asserted at cycle 5 of CALC → result=0, result_valid=0, stall_req=0 next cycle. Also: start held high in DONE keeps result stable; dropping start returns to IDLE and clears result_valid.

Source files
------------

// File: rtl/mips_div_unit.sv
// ---------------------------------------------------------------------------
// mips_div_unit
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the E stage.
// Produces {HI=remainder, LO=quotient}, stalls the pipeline while iterating,
// and can be aborted by an exception/branch flush (annul).
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   start        E-stage instruction is DIV/DIVU (level, held while stalled)
//   is_signed    1 = DIV, 0 = DIVU; sampled with start in IDLE
//   annul        flush; aborts any operation in progress (highest priority)
//   opdata1      dividend (rs), sampled in IDLE
//   opdata2      divisor (rt), sampled in IDLE
//   result       {remainder, quotient}, holds its last value
//   result_valid result holds the answer for the current start
//   stall_req    combinational stall request for E and earlier stages
// ---------------------------------------------------------------------------
module mips_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               is_signed,
   input  logic               annul,
   input  logic [WIDTH-1:0]   opdata1,
   input  logic [WIDTH-1:0]   opdata2,
   output logic [2*WIDTH-1:0] result,
   output logic               result_valid,
   output logic               stall_req
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ZERO = 2'd1,
      S_CALC = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Two's-complement negation, used for operand magnitudes and sign fix-up.
   function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
      return ~x + WIDTH'(1);
   endfunction

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d;      // partial remainder
   logic [WIDTH-1:0]   dvd_q, dvd_d;      // dividend, shifted out MSB first; quotient shifts in at LSB
   logic [WIDTH-1:0]   dvs_q, dvs_d;      // divisor magnitude
   logic               sign1_q, sign1_d;
   logic               sign2_q, sign2_d;
   logic               signed_q, signed_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               valid_q, valid_d;

   logic [WIDTH:0]     rem_sh_s;          // one extra bit: shifted remainder can reach 2*divisor-1
   logic               ge_s;
   logic [WIDTH-1:0]   rem_nx_s;
   logic [WIDTH-1:0]   quot_nx_s;
   logic [WIDTH-1:0]   quot_fix_s;
   logic [WIDTH-1:0]   rem_fix_s;
   logic [WIDTH-1:0]   mag1_s;
   logic [WIDTH-1:0]   mag2_s;

   assign result       = result_q;
   assign result_valid = valid_q;

   // Next-state, datapath and stall request.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      sign1_d   = sign1_q;
      sign2_d   = sign2_q;
      signed_d  = signed_q;
      result_d  = result_q;
      valid_d   = valid_q;
      stall_req = 1'b0;

      mag1_s = (is_signed && opdata1[WIDTH-1]) ? neg(opdata1) : opdata1;
      mag2_s = (is_signed && opdata2[WIDTH-1]) ? neg(opdata2) : opdata2;

      // One restoring step. When ge_s is set the difference is below the
      // divisor, so the low WIDTH bits of the subtraction are exact.
      rem_sh_s  = {rem_q, dvd_q[WIDTH-1]};
      ge_s      = (rem_sh_s >= {1'b0, dvs_q});
      rem_nx_s  = ge_s ? (rem_sh_s[WIDTH-1:0] - dvs_q) : rem_sh_s[WIDTH-1:0];
      quot_nx_s = {dvd_q[WIDTH-2:0], ge_s};

      // Quotient takes the XOR of the signs, remainder the dividend's sign.
      quot_fix_s = (signed_q && (sign1_q ^ sign2_q)) ? neg(quot_nx_s) : quot_nx_s;
      rem_fix_s  = (signed_q && sign1_q) ? neg(rem_nx_s) : rem_nx_s;

      case (state_q)
         S_IDLE: begin
            valid_d = 1'b0;
            if (start && !annul) begin
               stall_req = 1'b1;
               sign1_d   = opdata1[WIDTH-1];
               sign2_d   = opdata2[WIDTH-1];
               signed_d  = is_signed;
               dvs_d     = mag2_s;
               rem_d     = '0;
               cnt_d     = '0;
               if (opdata2 == '0) begin
                  // Divide by zero reports the untouched dividend in HI.
                  dvd_d   = opdata1;
                  state_d = S_ZERO;
               end else begin
                  dvd_d   = mag1_s;
                  state_d = S_CALC;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ZERO: begin
            stall_req = 1'b1;
            if (annul) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
            end else begin
               result_d = {dvd_q, {WIDTH{1'b1}}};
               valid_d  = 1'b1;
               state_d  = S_DONE;
            end
         end
         S_CALC: begin
            stall_req = 1'b1;
            if (annul) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
            end else begin
               rem_d = rem_nx_s;
               dvd_d = quot_nx_s;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  result_d = {rem_fix_s, quot_fix_s};
                  valid_d  = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_DONE: begin
            // Hold the answer until the pipeline advances (start drops).
            if (annul || !start) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         sign1_q  <= 1'b0;
         sign2_q  <= 1'b0;
         signed_q <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         sign1_q  <= sign1_d;
         sign2_q  <= sign2_d;
         signed_q <= signed_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

endmodule

// File: tb/tb_mips_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_div_unit
// Directed bench for mips_div_unit. A latency/arithmetic reference model
// predicts stall_req, result_valid and result every cycle; directed vectors
// additionally pin results and latencies to hand-computed literals.
// ---------------------------------------------------------------------------
module tb_mips_div_unit;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          is_signed;
   logic          annul;
   logic [W-1:0]  op1;
   logic [W-1:0]  op2;
   logic [2*W-1:0] result;
   logic          result_valid;
   logic          stall_req;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mips_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .is_signed    (is_signed),
      .annul        (annul),
      .opdata1      (op1),
      .opdata2      (op2),
      .result       (result),
      .result_valid (result_valid),
      .stall_req    (stall_req)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // MIPS division by plain arithmetic on 64-bit magnitudes (truncating).
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic neg_a, neg_b;
      longint unsigned ma, mb, q, r;
      logic [31:0] q32, r32;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      neg_a = s & a[31];
      neg_b = s & b[31];
      ma = neg_a ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
      mb = neg_b ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
      q = ma / mb;
      r = ma % mb;
      q32 = q[31:0];
      r32 = r[31:0];
      if (neg_a ^ neg_b) q32 = 32'd0 - q32;
      if (neg_a)         r32 = 32'd0 - r32;
      return {r32, q32};
   endfunction

   // Reference model: idle / busy for a fixed latency / holding an answer.
   int          m_phase = 0;
   int          m_left  = 0;
   logic [63:0] m_ans;
   logic [63:0] m_result = 64'd0;
   logic        m_valid  = 1'b0;
   bit          m_ready  = 1'b0;

   always @(posedge clk) begin
      m_ready <= 1'b1;
      if (rst) begin
         m_phase  <= 0;
         m_valid  <= 1'b0;
         m_result <= 64'd0;
      end else if (annul) begin
         m_phase <= 0;
         m_valid <= 1'b0;
      end else begin
         case (m_phase)
            0: if (start) begin
                  m_ans   <= ref_div(op1, op2, is_signed);
                  m_left  <= (op2 == 32'd0) ? 1 : W;
                  m_phase <= 1;
               end
            1: begin
                  m_left <= m_left - 1;
                  if (m_left == 1) begin
                     m_result <= m_ans;
                     m_valid  <= 1'b1;
                     m_phase  <= 2;
                  end
               end
            2: if (!start) begin
                  m_phase <= 0;
                  m_valid <= 1'b0;
               end
            default: m_phase <= 0;
         endcase
      end
   end

   // Every-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (m_ready) begin
         chk("stall_req", 64'(stall_req),
             64'((m_phase == 1) || (m_phase == 0 && start && !annul)));
         chk("result_valid", 64'(result_valid), 64'(m_valid));
         chk("result", result, m_result);
      end
   end

   // Issue one divide, scramble operands after acceptance, measure latency,
   // hold start in DONE for two cycles, then release.
   task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp, input int exp_lat);
      int lat;
      @(posedge clk); #1;
      start = 1'b1; is_signed = s; op1 = a; op2 = b;
      lat = 0;
      while (!result_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) begin op1 = ~a; op2 = ~b; is_signed = ~s; end
      end
      chk({name, " latency"}, 64'(lat), 64'(exp_lat));
      chk({name, " result"}, result, exp);
      repeat (2) @(posedge clk);
      #1;
      chk({name, " held"}, result, exp);
      start = 1'b0;
      @(posedge clk); #1;
      chk({name, " cleared"}, 64'(result_valid), 64'd0);
      chk({name, " kept"}, result, exp);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; is_signed = 1'b0; annul = 1'b0;
      op1 = 32'd0; op2 = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset result", result, 64'd0);
      chk("reset valid", 64'(result_valid), 64'd0);
      chk("reset stall", 64'(stall_req), 64'd0);
      rst = 1'b0;

      run_div("divu_7_2",   32'd7,          32'd2,          1'b0, 64'h0000_0001_0000_0003, 33);
      run_div("div_m7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 33);
      run_div("div_7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, 64'h0000_0001_FFFF_FFFD, 33);
      run_div("divu_by0",   32'h1234_5678,  32'd0,          1'b0, 64'h1234_5678_FFFF_FFFF, 2);
      run_div("div_by0",    32'h1234_5678,  32'd0,          1'b1, 64'h1234_5678_FFFF_FFFF, 2);
      run_div("div_neg_by0",32'h8765_4321,  32'd0,          1'b1, 64'h8765_4321_FFFF_FFFF, 2);
      run_div("div_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 64'h0000_0000_8000_0000, 33);
      run_div("divu_max_1", 32'hFFFF_FFFF,  32'd1,          1'b0, 64'h0000_0000_FFFF_FFFF, 33);
      run_div("div_m100_m7",32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 64'hFFFF_FFFE_0000_000E, 33);
      run_div("divu_mixed", 32'hDEAD_BEEF,  32'h0000_1234,  1'b0,
              ref_div(32'hDEAD_BEEF, 32'h0000_1234, 1'b0), 33);

      // Annul ten cycles into the iteration.
      @(posedge clk); #1;
      start = 1'b1; is_signed = 1'b0; op1 = 32'd1000; op2 = 32'd3;
      repeat (11) @(posedge clk);
      #1;
      annul = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      chk("annul valid", 64'(result_valid), 64'd0);
      chk("annul stall", 64'(stall_req), 64'd0);
      annul = 1'b0;
      repeat (2) @(posedge clk);
      run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 64'h0000_0002_0000_000E, 33);

      // Reset five cycles into the iteration.
      @(posedge clk); #1;
      start = 1'b1; is_signed = 1'b0; op1 = 32'hFFFF_FFFF; op2 = 32'd5;
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      chk("midrst result", result, 64'd0);
      chk("midrst valid", 64'(result_valid), 64'd0);
      chk("midrst stall", 64'(stall_req), 64'd0);
      rst = 1'b0;
      run_div("post_rst", 32'd9, 32'd4, 1'b0, 64'h0000_0001_0000_0002, 33);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
